// File: rtl/cnt_sequencer.sv
// cnt_sequencer: start/pause/clear controlled up-counter with a latched terminal count,
// one-shot or auto-repeat, and registered state/busy/done outputs.
module cnt_sequencer #(
    parameter int CNT_BIT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_pause,
    input  logic                     i_clear,
    input  logic                     i_repeat,
    input  logic [CNT_BIT_WIDTH-1:0] i_limit,
    output logic [CNT_BIT_WIDTH-1:0] o_cnt,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [1:0]               o_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

    state_t                   r_state, w_state_nx;
    logic [CNT_BIT_WIDTH-1:0] r_cnt, w_cnt_nx, r_limit, w_limit_nx;
    logic                     r_done, w_done_nx, r_busy, w_busy_nx;
    logic                     w_idle_like, w_terminal;

    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_terminal  = (r_cnt == r_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_limit <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_limit <= w_limit_nx;
            r_done  <= w_done_nx;
            r_busy  <= w_busy_nx;
        end
    end

    // Priority chain: clear > start > pause > terminal/increment.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_limit_nx = r_limit;
        w_done_nx  = 1'b0;
        if (i_clear) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
        end else if (i_start && w_idle_like) begin
            w_state_nx = RUN;
            w_cnt_nx   = '0;
            w_limit_nx = i_limit;
        end else if (i_pause && r_state == RUN) begin
            w_state_nx = PAUSE;
        end else if (i_pause && r_state == PAUSE) begin
            w_state_nx = RUN;
        end else if (r_state == RUN) begin
            w_done_nx  = w_terminal;
            w_cnt_nx   = w_terminal ? (i_repeat ? '0 : r_cnt) : r_cnt + 1'b1;
            w_state_nx = (w_terminal && !i_repeat) ? DONE : RUN;
        end
        w_busy_nx = (w_state_nx == RUN) || (w_state_nx == PAUSE);
    end

    assign o_cnt   = r_cnt;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_state = r_state;
endmodule

// File: tb/tb_cnt_sequencer.sv
// tb_cnt_sequencer: directed scenario tests for cnt_sequencer; each check compares the
// packed status {state, busy, done, cnt} against hand-computed values.
module tb_cnt_sequencer;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n, i_start, i_pause, i_clear, i_repeat;
    logic [3:0] i_limit, o_cnt;
    logic       o_busy, o_done;
    logic [1:0] o_state;
    int         n_checks = 0;
    int         n_fail = 0;

    cnt_sequencer #(.CNT_BIT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_pause(i_pause), .i_clear(i_clear),
        .i_repeat(i_repeat), .i_limit(i_limit), .o_cnt(o_cnt), .o_busy(o_busy),
        .o_done(o_done), .o_state(o_state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 0; i_pause = 0; i_clear = 0; i_repeat = 0; i_limit = 4'd0;
        tick(); tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_IDLE, 1'b0, 1'b0, 4'd0}) begin n_fail++; $display("FAIL reset: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_IDLE, 1'b0, 1'b0, 4'd0}); end
        rst_n = 1'b1;
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_IDLE, 1'b0, 1'b0, 4'd0}) begin n_fail++; $display("FAIL reset_release_idle: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_IDLE, 1'b0, 1'b0, 4'd0}); end
    endtask

    task automatic test_one_shot();
        i_limit = 4'd3; i_repeat = 0; i_start = 1;
        tick();
        i_start = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL oneshot_start: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd0}); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'(i)}) begin n_fail++; $display("FAIL oneshot_cnt%0d: got %h expected %h", i, {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'(i)}); end
        end
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_DONE, 1'b0, 1'b1, 4'd3}) begin n_fail++; $display("FAIL oneshot_done: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_DONE, 1'b0, 1'b1, 4'd3}); end
        i_pause = 1;
        tick();
        i_pause = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_DONE, 1'b0, 1'b0, 4'd3}) begin n_fail++; $display("FAIL oneshot_done_single_pulse: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_DONE, 1'b0, 1'b0, 4'd3}); end
    endtask

    task automatic test_repeat();
        i_limit = 4'd2; i_repeat = 1; i_start = 1;
        tick();
        i_limit = 4'd9;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL repeat_start: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd0}); end
        for (int i = 1; i <= 7; i++) begin
            tick();
            i_start = 0;
            n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'(i % 3 == 0), 4'(i % 3)}) begin n_fail++; $display("FAIL repeat_step%0d: got %h expected %h", i, {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'(i % 3 == 0), 4'(i % 3)}); end
        end
        i_clear = 1;
        tick();
        i_clear = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_IDLE, 1'b0, 1'b0, 4'd0}) begin n_fail++; $display("FAIL repeat_clear: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_IDLE, 1'b0, 1'b0, 4'd0}); end
    endtask

    task automatic test_pause();
        i_limit = 4'd5; i_repeat = 0; i_start = 1;
        tick();
        i_start = 0;
        tick(); tick();
        i_pause = 1;
        tick();
        i_pause = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_PAUSE, 1'b1, 1'b0, 4'd2}) begin n_fail++; $display("FAIL pause_enter: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_PAUSE, 1'b1, 1'b0, 4'd2}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_PAUSE, 1'b1, 1'b0, 4'd2}) begin n_fail++; $display("FAIL pause_hold%0d: got %h expected %h", i, {o_state, o_busy, o_done, o_cnt}, {S_PAUSE, 1'b1, 1'b0, 4'd2}); end
        end
        i_pause = 1;
        tick();
        i_pause = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd2}) begin n_fail++; $display("FAIL pause_resume: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd2}); end
        for (int i = 3; i <= 5; i++) begin
            tick();
            n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'(i)}) begin n_fail++; $display("FAIL pause_cnt%0d: got %h expected %h", i, {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'(i)}); end
        end
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_DONE, 1'b0, 1'b1, 4'd5}) begin n_fail++; $display("FAIL pause_done: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_DONE, 1'b0, 1'b1, 4'd5}); end
    endtask

    task automatic test_priority();
        i_clear = 1;
        tick();
        i_start = 1; i_limit = 4'd1;
        tick();
        i_start = 0; i_clear = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_IDLE, 1'b0, 1'b0, 4'd0}) begin n_fail++; $display("FAIL prio_clear_over_start: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_IDLE, 1'b0, 1'b0, 4'd0}); end
        i_start = 1;
        tick();
        i_start = 0;
        tick();
        i_pause = 1;
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_PAUSE, 1'b1, 1'b0, 4'd1}) begin n_fail++; $display("FAIL prio_pause_over_terminal: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_PAUSE, 1'b1, 1'b0, 4'd1}); end
        tick();
        i_pause = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd1}) begin n_fail++; $display("FAIL prio_unpause: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd1}); end
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_DONE, 1'b0, 1'b1, 4'd1}) begin n_fail++; $display("FAIL prio_terminal_after_pause: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_DONE, 1'b0, 1'b1, 4'd1}); end
    endtask

    task automatic test_boundary();
        i_limit = 4'd15; i_repeat = 0; i_start = 1;
        tick();
        i_start = 0;
        for (int i = 1; i <= 15; i++) tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd15}) begin n_fail++; $display("FAIL bound_cnt15: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd15}); end
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_DONE, 1'b0, 1'b1, 4'd15}) begin n_fail++; $display("FAIL bound_done15: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_DONE, 1'b0, 1'b1, 4'd15}); end
        i_limit = 4'd0; i_repeat = 1; i_start = 1;
        tick();
        i_start = 0;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL bound_zero_start: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd0}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b1, 4'd0}) begin n_fail++; $display("FAIL bound_zero_repeat%0d: got %h expected %h", i, {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b1, 4'd0}); end
        end
        i_repeat = 0;
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_DONE, 1'b0, 1'b1, 4'd0}) begin n_fail++; $display("FAIL bound_zero_live_repeat: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_DONE, 1'b0, 1'b1, 4'd0}); end
    endtask

    task automatic test_reset_mid_run();
        i_limit = 4'd7; i_repeat = 0; i_start = 1;
        tick();
        i_start = 0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd4}) begin n_fail++; $display("FAIL rstmid_pre: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd4}); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_IDLE, 1'b0, 1'b0, 4'd0}) begin n_fail++; $display("FAIL rstmid_async: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_IDLE, 1'b0, 1'b0, 4'd0}); end
        #1 rst_n = 1'b1;
        tick(); tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_IDLE, 1'b0, 1'b0, 4'd0}) begin n_fail++; $display("FAIL rstmid_stay_idle: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_IDLE, 1'b0, 1'b0, 4'd0}); end
        i_start = 1;
        tick();
        i_start = 0;
        tick();
        n_checks++; if ({o_state, o_busy, o_done, o_cnt} !== {S_RUN, 1'b1, 1'b0, 4'd1}) begin n_fail++; $display("FAIL rstmid_restart: got %h expected %h", {o_state, o_busy, o_done, o_cnt}, {S_RUN, 1'b1, 1'b0, 4'd1}); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_repeat();
        test_pause();
        test_priority();
        test_boundary();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/cnt_sequencer.md
CNT_SEQUENCER -- requirements
Module: cnt_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_BIT_WIDTH, default 4, setting the width of the count and the limit.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset; rst_n is asynchronous, active-low; clock is clk.
REQ-004 The block SHALL have port start  input  1  one-cycle request to begin a count run.
REQ-005 The block SHALL have port pause  input  1  one-cycle toggle between running and paused.
REQ-006 The block SHALL have port clear  input  1  synchronous abort to idle.
REQ-007 The block SHALL have port repeat  input  1  1 = auto-restart at terminal count; 0 = one-shot.
REQ-008 The block SHALL have port limit  input  CNT_BIT_WIDTH  terminal count value, sampled only on an accepted start.
REQ-009 The block SHALL have port cnt  output  CNT_BIT_WIDTH  registered count value.
REQ-010 The block SHALL have port busy  output  1  registered; 1 in RUN or PAUSE.
REQ-011 The block SHALL have port done  output  1  registered one-cycle terminal-count pulse.
REQ-012 The block SHALL have port state  output  2  registered state code: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-013 The block SHALL implement a 4-state FSM (IDLE, RUN, PAUSE, DONE), with all outputs driven from registers.
REQ-014 Input priority SHALL be clear > start > pause > terminal/increment, evaluated on every rising clk edge.
REQ-015 clear=1 in any state SHALL force IDLE, cnt=0 and done=0 at that edge.
REQ-016 IDLE or DONE with start=1 SHALL transition to RUN, latch limit into limit_q, and set cnt=0.
REQ-017 start=1 while in RUN or PAUSE SHALL be ignored (no restart, no re-sample of limit).
REQ-018 pause=1 while in IDLE or DONE SHALL be ignored.
REQ-019 RUN with pause=1 SHALL transition to PAUSE with cnt held and no done pulse, even if cnt==limit_q.
REQ-020 PAUSE with pause=1 SHALL transition to RUN; otherwise PAUSE SHALL hold cnt and state.
REQ-021 RUN with cnt!=limit_q SHALL set cnt = cnt+1 (modulo 2^CNT_BIT_WIDTH) at each edge.
REQ-022 RUN with cnt==limit_q and repeat=1 SHALL set cnt=0, stay in RUN, and set done=1 for one cycle.
REQ-023 RUN with cnt==limit_q and repeat=0 SHALL transition to DONE, hold cnt=limit_q, and set done=1 for one cycle.
REQ-024 repeat SHALL be sampled live at each terminal edge and SHALL NOT be latched at start.
REQ-025 done SHALL be 0 on every edge where no terminal action occurs, so it is never high for two consecutive cycles except when limit_q=0 with repeat=1.
REQ-026 limit_q=0 with repeat=1 SHALL hold cnt=0 with done=1 on every RUN cycle; with repeat=0 it SHALL enter DONE one edge after start.
REQ-027 A run of limit_q=L SHALL produce done L+1 edges after the start edge, excluding paused cycles.
REQ-028 Changes on limit after an accepted start SHALL have no effect until the next accepted start.

Reset
REQ-029 rst_n=0 SHALL immediately and asynchronously force state=IDLE, cnt=0, limit_q=0, busy=0, done=0, independent of clk.
REQ-030 Reset asserted mid-run or mid-pause SHALL discard the run; after release the block SHALL remain in IDLE until start.

Verification
REQ-031 Scenario one-shot: limit=3, repeat=0, start pulse -> cnt 0,1,2,3 on consecutive cycles, then state=DONE, cnt=3, done=1 for exactly one cycle, busy=0.
REQ-032 Scenario repeat: limit=2, repeat=1 -> cnt 0,1,2,0,1,2,... with done=1 each cycle cnt returns to 0; changing limit to 9 mid-run has no effect.
REQ-033 Scenario pause: limit=5, pause at cnt=2, hold 4 cycles, pause again -> cnt stays 2 for 4 cycles, state=10, then resumes 3,4,5 and gives done.
REQ-034 Scenario priority: start and clear in the same cycle from IDLE -> stays IDLE with cnt=0; pause and cnt==limit_q in the same cycle -> PAUSE, no done.
REQ-035 Scenario boundary: limit=15, repeat=0 -> cnt reaches 15 without wrapping, enters DONE; limit=0, repeat=1 -> done continuously high in RUN with cnt=0.
REQ-036 Scenario reset: rst_n low mid-count at cnt=4, between clock edges -> cnt=0 and state=00 before the next edge; start after release restarts from 0.
